// File: rtl/cla_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Slice width, FSM state encoding and index-width helper.
package cla_serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead slice; purely combinational.
// sum[4] is the slice carry-out.
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [4:0] sum
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign sum = {w_c[4], w_p ^ w_c[3:0]};

endmodule

// File: rtl/cla_serial_adder.sv
// Nibble-serial wide adder: one CLA slice reused per cycle,
// carry chained through r_carry, result held until handshake.
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int IW      = idx_w(NSLICES);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be a multiple of 4, >= 4");
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_live;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_res;

  logic             w_acc;
  logic             w_last;
  logic [3:0]       w_sa;
  logic [3:0]       w_sb;
  logic [4:0]       w_s;

  assign w_acc  = in_valid & in_ready;
  assign w_last = (r_idx == IW'(NSLICES - 1));
  assign w_sa   = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_sb   = r_b[r_idx*SLICE_W +: SLICE_W];

  cla_adder u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .c_in (r_carry),
    .sum  (w_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // in_ready stays low for the first cycle out of reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE:    in_ready  = r_live;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_acc) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_carry <= in_cin;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_res[r_idx*SLICE_W +: SLICE_W] <= w_s[3:0];
        r_carry <= w_s[4];
        if (w_last) begin
          r_res[WIDTH] <= w_s[4];
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign out_sum = r_res;

endmodule
